// File: rtl/bitcalc_writeback.sv
// bitcalc_writeback: writeback stage behind the 4-bit bit-operation unit.
// Buffers results in a small FIFO and drains one per cycle into the register file.
//
// Ports:
//   CLK, RESET            rising-edge clock, async active-high reset
//   IN_VALID/IN_READY     upstream handshake
//   IN_DATA/IN_ZERO       result value and its zero flag
//   IN_FLAG_WE/IN_DEST    Z-flag update enable, destination register index
//   WR_HOLD               stalls the drain for this cycle
//   RADDR1/2, RDATA1/2    committed register read ports (combinational)
//   ZFLAG                 committed Z flag
//   HAZARD1/2             a buffered entry targets RADDR1/2
//   COUNT                 number of buffered entries
module bitcalc_writeback #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2,
    parameter int AW    = 2,
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] IN_DATA,
    input  logic             IN_ZERO,
    input  logic             IN_FLAG_WE,
    input  logic [AW-1:0]    IN_DEST,
    input  logic             WR_HOLD,
    input  logic [AW-1:0]    RADDR1,
    input  logic [AW-1:0]    RADDR2,
    output logic [WIDTH-1:0] RDATA1,
    output logic [WIDTH-1:0] RDATA2,
    output logic             ZFLAG,
    output logic             HAZARD1,
    output logic             HAZARD2,
    output logic [CW-1:0]    COUNT
);

    localparam int PW   = $clog2(DEPTH);
    localparam int NREG = 1 << AW;

    logic [WIDTH-1:0] fifo_data [DEPTH];
    logic             fifo_zero [DEPTH];
    logic             fifo_fwe  [DEPTH];
    logic [AW-1:0]    fifo_dest [DEPTH];

    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    count;

    logic [WIDTH-1:0] regs [NREG];
    logic             zflag;

    logic             push;
    logic             pop;
    logic [DEPTH-1:0] live;
    logic [PW-1:0]    off;
    logic             haz1;
    logic             haz2;

    // Ready comes only from registered occupancy, so a full FIFO
    // stays closed for the cycle in which it drains.
    assign IN_READY = (count != CW'(DEPTH));
    assign push     = IN_VALID & IN_READY;
    assign pop      = (count != '0) & ~WR_HOLD;

    // Storage is not reset; occupancy alone decides what is valid.
    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_data[wr_ptr] <= IN_DATA;
            fifo_zero[wr_ptr] <= IN_ZERO;
            fifo_fwe[wr_ptr]  <= IN_FLAG_WE;
            fifo_dest[wr_ptr] <= IN_DEST;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
            zflag <= 1'b1;
        end else if (pop) begin
            regs[fifo_dest[rd_ptr]] <= fifo_data[rd_ptr];
            if (fifo_fwe[rd_ptr]) begin
                zflag <= fifo_zero[rd_ptr];
            end
        end
    end

    // A slot is live when its distance from the head is below COUNT.
    always_comb begin
        live = '0;
        off  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off     = PW'(i) - rd_ptr;
            live[i] = ({1'b0, off} < count);
        end
    end

    always_comb begin
        haz1 = 1'b0;
        haz2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live[i] && (fifo_dest[i] == RADDR1)) begin
                haz1 = 1'b1;
            end
            if (live[i] && (fifo_dest[i] == RADDR2)) begin
                haz2 = 1'b1;
            end
        end
    end

    assign HAZARD1 = haz1;
    assign HAZARD2 = haz2;
    assign RDATA1  = regs[RADDR1];
    assign RDATA2  = regs[RADDR2];
    assign ZFLAG   = zflag;
    assign COUNT   = count;

endmodule

// File: tb/tb_bitcalc_writeback.sv
// tb_bitcalc_writeback: directed and random stimulus for bitcalc_writeback,
// checked against a queue-based reference model.
module tb_bitcalc_writeback;

    localparam int DEPTH = 2;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       IN_VALID;
    logic       IN_READY;
    logic [3:0] IN_DATA;
    logic       IN_ZERO;
    logic       IN_FLAG_WE;
    logic [1:0] IN_DEST;
    logic       WR_HOLD;
    logic [1:0] RADDR1;
    logic [1:0] RADDR2;
    logic [3:0] RDATA1;
    logic [3:0] RDATA2;
    logic       ZFLAG;
    logic       HAZARD1;
    logic       HAZARD2;
    logic [1:0] COUNT;

    bitcalc_writeback #(.WIDTH(4), .DEPTH(DEPTH), .AW(2)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .IN_DATA   (IN_DATA),
        .IN_ZERO   (IN_ZERO),
        .IN_FLAG_WE(IN_FLAG_WE),
        .IN_DEST   (IN_DEST),
        .WR_HOLD   (WR_HOLD),
        .RADDR1    (RADDR1),
        .RADDR2    (RADDR2),
        .RDATA1    (RDATA1),
        .RDATA2    (RDATA2),
        .ZFLAG     (ZFLAG),
        .HAZARD1   (HAZARD1),
        .HAZARD2   (HAZARD2),
        .COUNT     (COUNT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [3:0] d;
        logic       z;
        logic       f;
        logic [1:0] a;
    } ent_t;

    ent_t       q[$];
    logic [3:0] mregs [4];
    logic       mz;
    int         checks = 0;
    int         passes = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        q.delete();
        for (int i = 0; i < 4; i++) mregs[i] = '0;
        mz = 1'b1;
    endtask

    task automatic model_step();
        bit   rdy;
        bit   pp;
        bit   ps;
        ent_t e;
        rdy = (q.size() != DEPTH);
        pp  = (q.size() != 0) && !WR_HOLD;
        ps  = IN_VALID && rdy;
        if (pp) begin
            e = q.pop_front();
            mregs[e.a] = e.d;
            if (e.f) mz = e.z;
        end
        if (ps) begin
            e.d = IN_DATA;
            e.z = IN_ZERO;
            e.f = IN_FLAG_WE;
            e.a = IN_DEST;
            q.push_back(e);
        end
    endtask

    task automatic settle_check();
        bit h1;
        bit h2;
        #2;
        h1 = 0;
        h2 = 0;
        foreach (q[i]) begin
            if (q[i].a == RADDR1) h1 = 1;
            if (q[i].a == RADDR2) h2 = 1;
        end
        check("ready", IN_READY, q.size() != DEPTH);
        check("count", COUNT, q.size());
        check("rdata1", RDATA1, mregs[RADDR1]);
        check("rdata2", RDATA2, mregs[RADDR2]);
        check("zflag", ZFLAG, mz);
        check("hazard1", HAZARD1, h1);
        check("hazard2", HAZARD2, h2);
    endtask

    task automatic cycle();
        @(posedge CLK);
        if (!RESET) model_step();
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] d, input logic z,
                         input logic f, input logic [1:0] a, input logic h);
        IN_VALID   = v;
        IN_DATA    = d;
        IN_ZERO    = z;
        IN_FLAG_WE = f;
        IN_DEST    = a;
        WR_HOLD    = h;
    endtask

    task automatic step(input logic v, input logic [3:0] d, input logic z,
                        input logic f, input logic [1:0] a, input logic h);
        drive(v, d, z, f, a, h);
        settle_check();
        cycle();
    endtask

    task automatic async_reset();
        RESET = 1'b1;
        #1;
        model_reset();
        check("rst_count", COUNT, 0);
        check("rst_ready", IN_READY, 1);
        check("rst_zflag", ZFLAG, 1);
        check("rst_haz1", HAZARD1, 0);
        settle_check();
        RESET = 1'b0;
    endtask

    initial begin
        RESET  = 1'b1;
        RADDR1 = 2'd0;
        RADDR2 = 2'd0;
        drive(0, 0, 0, 0, 0, 0);
        model_reset();
        #2;
        check("por_count", COUNT, 0);
        check("por_ready", IN_READY, 1);
        check("por_zflag", ZFLAG, 1);
        check("por_rdata1", RDATA1, 0);
        #10;
        RESET = 1'b0;
        @(posedge CLK);
        #1;

        // single push, latency and hazard
        RADDR1 = 2'd2;
        step(1, 4'hA, 0, 1, 2'd2, 0);
        drive(0, 0, 0, 0, 0, 0);
        settle_check();
        check("t1_haz1", HAZARD1, 1);
        cycle();
        settle_check();
        check("t1_rdata1", RDATA1, 4'hA);
        check("t1_zflag", ZFLAG, 0);
        check("t1_count", COUNT, 0);

        // fill under hold, then release
        step(1, 4'h1, 0, 0, 2'd0, 1);
        step(1, 4'h2, 0, 0, 2'd1, 1);
        drive(1, 4'h3, 0, 0, 2'd3, 1);
        settle_check();
        check("t2_ready", IN_READY, 0);
        check("t2_count", COUNT, 2);
        cycle();
        step(1, 4'h3, 0, 0, 2'd3, 0);
        drive(1, 4'h3, 0, 0, 2'd3, 0);
        settle_check();
        check("t2_ready2", IN_READY, 1);
        cycle();
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0);
        RADDR1 = 2'd3;
        settle_check();
        check("t2_r3", RDATA1, 4'h3);

        // same destination twice
        RADDR2 = 2'd1;
        step(1, 4'h3, 0, 0, 2'd1, 0);
        drive(1, 4'h5, 0, 0, 2'd1, 0);
        settle_check();
        check("t3_haz2a", HAZARD2, 1);
        cycle();
        drive(0, 0, 0, 0, 0, 0);
        settle_check();
        check("t3_haz2b", HAZARD2, 1);
        cycle();
        settle_check();
        check("t3_haz2c", HAZARD2, 0);
        check("t3_r1", RDATA2, 4'h5);

        // Z flag update enable
        step(1, 4'h4, 0, 1, 2'd0, 0);
        step(1, 4'h0, 1, 0, 2'd0, 0);
        step(0, 0, 0, 0, 0, 0);
        settle_check();
        check("t4_z0", ZFLAG, 0);
        step(1, 4'h0, 1, 1, 2'd0, 0);
        step(0, 0, 0, 0, 0, 0);
        settle_check();
        check("t4_z1", ZFLAG, 1);

        // streaming with pointer wrap
        for (int i = 0; i < 10; i++) begin
            RADDR1 = 2'(i);
            drive(1, 4'(i + 3), 0, 1, 2'(i), 0);
            settle_check();
            if (i > 0) check("t5_count", COUNT, 1);
            cycle();
        end
        step(0, 0, 0, 0, 0, 0);

        // async reset with two buffered entries
        step(1, 4'h7, 0, 1, 2'd1, 1);
        step(1, 4'h9, 0, 1, 2'd2, 1);
        drive(0, 0, 0, 0, 0, 1);
        #2;
        check("t6_pre_count", COUNT, 2);
        async_reset();
        cycle();
        for (int i = 0; i < 4; i++) begin
            RADDR1 = 2'(i);
            RADDR2 = 2'(3 - i);
            step(0, 0, 0, 0, 0, 0);
            check("t6_lost1", RDATA1, 0);
            check("t6_lost2", RDATA2, 0);
        end

        // random traffic
        for (int n = 0; n < 400; n++) begin
            RADDR1 = 2'($urandom_range(0, 3));
            RADDR2 = 2'($urandom_range(0, 3));
            drive($urandom_range(0, 9) < 7, 4'($urandom),
                  1'($urandom), 1'($urandom), 2'($urandom),
                  $urandom_range(0, 3) == 0);
            settle_check();
            if ($urandom_range(0, 99) == 0) async_reset();
            cycle();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
